// File: rtl/xor_nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_nn_pkg
// Description : Constants and state encodings shared by the XOR network core
//               and its batch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package xor_nn_pkg;

  // Register stages in the core from input_data to prediction_data.
  localparam int NN_LATENCY        = 3;
  localparam int DEFAULT_BATCH_MAX = 8;

  typedef enum logic [2:0] {
    ST_WARM  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/xor_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : xor_tag_pipe
// Description : Shift register of {valid, tag} entries that tracks samples
//               in flight through the core; the head lines up with the core
//               prediction for the sample that carries that tag.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_valid,
  input  logic [TAG_W-1:0] push_tag,
  output logic             head_valid,
  output logic [TAG_W-1:0] head_tag,
  output logic             empty,
  output logic             tail_empty
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][TAG_W-1:0] r_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      r_valid <= {r_valid[DEPTH-2:0], push_valid};
      r_tag   <= {r_tag[DEPTH-2:0], push_tag};
    end
  end

  assign head_valid = r_valid[DEPTH-1];
  assign head_tag   = r_tag[DEPTH-1];
  assign empty      = ~|r_valid;
  // Only the head (if anything) remains: the pipe is empty after the next edge.
  assign tail_empty = ~|r_valid[DEPTH-2:0];

endmodule
`default_nettype wire

// File: rtl/xor_batch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xor_batch_sequencer
// Description : Accepts a batch of 2-bit samples, issues them one per cycle
//               to the XOR core, gathers the predictions and returns them as
//               a packed result vector.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_batch_sequencer
  import xor_nn_pkg::*;
#(
  parameter int BATCH_MAX = DEFAULT_BATCH_MAX,
  parameter int CNT_W     = $clog2(BATCH_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [2*BATCH_MAX-1:0] s_data,
  input  logic [CNT_W-1:0]       s_count,
  output logic [1:0]             nn_input_data,
  input  logic                   nn_prediction,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [BATCH_MAX-1:0]   m_result,
  output logic [CNT_W-1:0]       m_count
);

  localparam int              PIPE_DEPTH  = NN_LATENCY + 1;
  localparam int              WARM_W      = $clog2(NN_LATENCY + 1) + 1;
  localparam logic [CNT_W-1:0] C_BATCH_MAX = CNT_W'(BATCH_MAX);
  localparam logic [WARM_W-1:0] C_WARM_END = WARM_W'(NN_LATENCY);

  seq_state_e             r_state;
  seq_state_e             w_next_state;
  logic [2*BATCH_MAX-1:0] r_data;
  logic [CNT_W-1:0]       r_n;
  logic [CNT_W-1:0]       r_idx;
  logic [WARM_W-1:0]      r_warm_cnt;
  logic [1:0]             r_nn_in;
  logic                   r_m_valid;
  logic [BATCH_MAX-1:0]   r_m_result;
  logic [CNT_W-1:0]       r_m_count;

  logic                   w_accept;
  logic                   w_issue;
  logic [CNT_W-1:0]       w_clamped_n;
  logic [1:0]             w_sample;
  logic                   w_head_valid;
  logic [CNT_W-1:0]       w_head_tag;
  logic                   w_pipe_empty;
  logic                   w_pipe_tail_empty;

  assign w_clamped_n = (s_count > C_BATCH_MAX) ? C_BATCH_MAX : s_count;

  always_comb begin
    w_sample = 2'b00;
    for (int i = 0; i < BATCH_MAX; i++) begin
      if (r_idx == CNT_W'(i)) w_sample = r_data[2*i +: 2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_WARM;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    s_ready      = 1'b0;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      ST_WARM: begin
        if (r_warm_cnt == C_WARM_END) w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        s_ready = w_pipe_empty;
        if (s_valid && w_pipe_empty) begin
          w_accept     = 1'b1;
          w_next_state = (w_clamped_n == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_issue = 1'b1;
        if (r_idx == r_n - CNT_W'(1)) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pipe_tail_empty) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (r_m_valid && m_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_WARM;
    endcase
  end

  // m_valid trails entry to DONE by one edge so the last capture has landed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm_cnt <= '0;
      r_data     <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_nn_in    <= 2'b00;
      r_m_valid  <= 1'b0;
      r_m_count  <= '0;
    end else begin
      if (r_state == ST_WARM) r_warm_cnt <= r_warm_cnt + WARM_W'(1);
      if (w_accept) begin
        r_data    <= s_data;
        r_n       <= w_clamped_n;
        r_idx     <= '0;
        r_m_count <= w_clamped_n;
      end else if (w_issue) begin
        r_idx <= r_idx + CNT_W'(1);
      end
      r_nn_in   <= w_issue ? w_sample : 2'b00;
      r_m_valid <= (r_state == ST_DONE) && !(r_m_valid && m_ready);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_result <= '0;
    end else if (w_accept) begin
      r_m_result <= '0;
    end else if (w_head_valid) begin
      for (int i = 0; i < BATCH_MAX; i++) begin
        if (w_head_tag == CNT_W'(i)) r_m_result[i] <= nn_prediction;
      end
    end
  end

  xor_tag_pipe #(
    .DEPTH (PIPE_DEPTH),
    .TAG_W (CNT_W)
  ) u_tag_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (w_issue),
    .push_tag   (r_idx),
    .head_valid (w_head_valid),
    .head_tag   (w_head_tag),
    .empty      (w_pipe_empty),
    .tail_empty (w_pipe_tail_empty)
  );

  assign nn_input_data = r_nn_in;
  assign m_valid       = r_m_valid;
  assign m_result      = r_m_result;
  assign m_count       = r_m_count;

endmodule
`default_nettype wire

// File: tb/tb_xor_batch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_batch_sequencer
// Description : Directed bench for xor_batch_sequencer driving a three-stage
//               XOR core model with no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_batch_sequencer;

  localparam int BATCH_MAX = 8;
  localparam int CNT_W     = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   s_valid;
  logic                   s_ready;
  logic [2*BATCH_MAX-1:0] s_data;
  logic [CNT_W-1:0]       s_count;
  logic [1:0]             nn_input_data;
  logic                   nn_prediction;
  logic                   m_valid;
  logic                   m_ready;
  logic [BATCH_MAX-1:0]   m_result;
  logic [CNT_W-1:0]       m_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Core model: h1, a1, prediction registers, no reset.
  logic [1:0] core_h1;
  logic       core_a1;
  logic       core_pred;
  always_ff @(posedge clk) begin
    core_h1   <= nn_input_data;
    core_a1   <= core_h1[1] ^ core_h1[0];
    core_pred <= core_a1;
  end
  assign nn_prediction = core_pred;

  xor_batch_sequencer #(
    .BATCH_MAX (BATCH_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_count       (s_count),
    .nn_input_data (nn_input_data),
    .nn_prediction (nn_prediction),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_result      (m_result),
    .m_count       (m_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one batch; returns 1ns after the accept edge with s_valid dropped.
  task automatic send(input logic [15:0] data, input logic [3:0] cnt);
    check("s_ready_before_send", s_ready, 1);
    s_valid = 1'b1;
    s_data  = data;
    s_count = cnt;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("m_valid_after_hs", m_valid, 0);
    check("s_ready_after_hs", s_ready, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_count = '0;
    m_ready = 1'b0;

    // 1: reset and warm-up
    tick();
    tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_nn_in", nn_input_data, 0);
    check("rst_m_result", m_result, 0);
    check("rst_m_count", m_count, 0);
    reset_n = 1'b1;
    check("warm0_s_ready", s_ready, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("warm_s_ready", s_ready, 0);
      check("warm_m_valid", m_valid, 0);
      check("warm_nn_in", nn_input_data, 0);
    end
    tick();
    check("warm_end_s_ready", s_ready, 1);

    // 2: four samples 00,01,10,11
    send(16'h00E4, 4'd4);
    check("b2_s_ready_busy", s_ready, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("b2_m_valid_low", m_valid, 0);
      if (k <= 4) check("b2_nn_in_seq", nn_input_data, k - 1);
      else        check("b2_nn_in_idle", nn_input_data, 0);
    end
    tick();
    check("b2_m_valid", m_valid, 1);
    check("b2_m_result", m_result, 8'h06);
    check("b2_m_count", m_count, 4);
    handshake();

    // 3: eight samples of 01, backpressure, stray s_valid ignored
    send(16'h5555, 4'd8);
    for (int k = 1; k <= 12; k++) tick();
    check("b3_m_valid_pre", m_valid, 0);
    tick();
    check("b3_m_valid", m_valid, 1);
    s_valid = 1'b1;
    s_data  = 16'h0000;
    s_count = 4'd2;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("b3_hold_m_valid", m_valid, 1);
      check("b3_hold_m_result", m_result, 8'hFF);
      check("b3_hold_m_count", m_count, 8);
      check("b3_hold_s_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    handshake();

    // 4a: empty batch
    send(16'h0000, 4'd0);
    check("b4a_m_valid_A", m_valid, 0);
    check("b4a_nn_in", nn_input_data, 0);
    tick();
    check("b4a_m_valid", m_valid, 1);
    check("b4a_m_result", m_result, 0);
    check("b4a_m_count", m_count, 0);
    handshake();

    // 4b: oversize count clamps to BATCH_MAX
    send(16'hAAAA, 4'd12);
    for (int k = 1; k <= 12; k++) tick();
    check("b4b_m_valid_pre", m_valid, 0);
    tick();
    check("b4b_m_valid", m_valid, 1);
    check("b4b_m_count", m_count, 8);
    check("b4b_m_result", m_result, 8'hFF);
    handshake();

    // 5: reset mid-batch, then a clean batch {00,11}
    send(16'h0055, 4'd4);
    tick();
    tick();
    tick();
    check("b5_nn_in_A3", nn_input_data, 2'b01);
    reset_n = 1'b0;
    #1;
    check("b5_rst_nn_in", nn_input_data, 0);
    check("b5_rst_m_valid", m_valid, 0);
    check("b5_rst_s_ready", s_ready, 0);
    check("b5_rst_m_result", m_result, 0);
    check("b5_rst_m_count", m_count, 0);
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("b5_warm_s_ready", s_ready, 0);
    end
    tick();
    send(16'h000C, 4'd2);
    for (int k = 1; k <= 6; k++) tick();
    check("b5_m_valid_pre", m_valid, 0);
    tick();
    check("b5_m_valid", m_valid, 1);
    check("b5_m_result", m_result, 8'h00);
    check("b5_m_count", m_count, 2);
    handshake();

    // 6: back-to-back batches with s_valid and m_ready held high
    s_valid = 1'b1;
    s_data  = 16'h0009;
    s_count = 4'd2;
    m_ready = 1'b1;
    tick();
    s_data  = 16'h0007;
    s_count = 4'd3;
    check("b6_s_ready_busy", s_ready, 0);
    for (int k = 1; k <= 6; k++) tick();
    tick();
    check("b6_1_m_valid", m_valid, 1);
    check("b6_1_m_result", m_result, 8'h03);
    check("b6_1_m_count", m_count, 2);
    tick();
    check("b6_hs_m_valid", m_valid, 0);
    check("b6_hs_s_ready", s_ready, 1);
    tick();
    check("b6_2_accepted", s_ready, 0);
    s_valid = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    check("b6_2_m_valid_pre", m_valid, 0);
    tick();
    check("b6_2_m_valid", m_valid, 1);
    check("b6_2_m_result", m_result, 8'h02);
    check("b6_2_m_count", m_count, 3);
    tick();
    check("b6_2_hs_m_valid", m_valid, 0);
    check("b6_2_hs_s_ready", s_ready, 1);
    m_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
